uart_tx_arbiter: RTL and testbench

- Shares the single UART TX FIFO write port (8-bit data, write strobe, fill count) among N byte-stream requesters.
- Arbitrates round-robin at packet granularity: the grant is held from the first byte to the byte flagged last.
- Flow control comes from the TX FIFO fill count, so the FIFO is never overfilled.
- A stall watchdog releases a hung requester. The block sits between the CPU-side/DMA byte sources and the UART TX FIFO in the UART subsystem.

---
 rtl/uart_arb_pkg.sv | 13 +
 rtl/uart_tx_arbiter_rr_picker.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter and its round-robin picker.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  localparam logic [4:0] HDR_PREFIX = 5'b10100;
  localparam int         IDX_W      = 3;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request searching upward from i_ptr+1, wrapping.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Outer loop walks priority distance, so the first hit is the closest after i_ptr.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int d = 0; d < N_REQ; d++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!o_any && i_req[j] && (j == (int'(i_ptr) + 1 + d) % N_REQ)) begin
          o_any       = 1'b1;
          o_onehot[j] = 1'b1;
          o_idx       = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the UART TX FIFO write port, with stall watchdog.
// Optional per-packet ID header byte is enabled by defining UART_ARB_ID_HDR_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int FIFO_DEPTH = 10,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic               i_sys_clk,
  input  logic               i_sys_rst,
  input  logic               i_module_en,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ready,
  input  logic [CNT_W-1:0]   i_fifo_cnt,
  output logic               o_fifo_wr,
  output logic [7:0]         o_fifo_din,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_busy,
  output logic               o_err_timeout,
  output logic [2:0]         o_err_id
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  arb_state_t       r_state, w_state_next;
  logic [N_REQ-1:0] r_grant, w_grant_next;
  logic [IDX_W-1:0] r_gidx, w_gidx_next;
  logic [IDX_W-1:0] r_rr_ptr, w_rr_ptr_next;
  logic [WD_W-1:0]  r_wd_cnt, w_wd_cnt_next;
  logic             r_fifo_wr, w_fifo_wr_next;
  logic [7:0]       r_fifo_din, w_fifo_din_next;
  logic             r_err_timeout, w_err_timeout_next;
  logic [IDX_W-1:0] r_err_id, w_err_id_next;

  logic [N_REQ-1:0]        w_pick_onehot;
  logic [IDX_W-1:0]        w_pick_idx;
  logic                    w_pick_any;
  logic [N_REQ-1:0][7:0]   w_masked;
  logic [7:0]              w_sel_data;
  logic                    w_sel_valid;
  logic                    w_sel_last;
  logic [CNT_W:0]          w_occ;
  logic                    w_space;
  logic                    w_in_data;
  logic                    w_xfer;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .i_req    (i_req_valid),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
    assign w_masked[gi] = i_req_data[8*gi +: 8] & {8{r_grant[gi]}};
  end

  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sel_data = w_sel_data | w_masked[k];
    end
  end

  assign w_sel_valid = |(i_req_valid & r_grant);
  assign w_sel_last  = |(i_req_last & r_grant);

  // The write registered last cycle is not yet reflected in the FIFO count.
  assign w_occ     = {1'b0, i_fifo_cnt} + {{CNT_W{1'b0}}, r_fifo_wr};
  assign w_space   = (w_occ < (CNT_W + 1)'(FIFO_DEPTH));
  assign w_in_data = (r_state == ST_DATA);
  assign w_xfer    = w_in_data & w_space & w_sel_valid;

  assign o_req_ready   = (w_in_data && w_space) ? r_grant : '0;
  assign o_fifo_wr     = r_fifo_wr;
  assign o_fifo_din    = r_fifo_din;
  assign o_grant       = r_grant;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_err_timeout = r_err_timeout;
  assign o_err_id      = r_err_id;

  always_comb begin
    w_state_next       = r_state;
    w_grant_next       = r_grant;
    w_gidx_next        = r_gidx;
    w_rr_ptr_next      = r_rr_ptr;
    w_wd_cnt_next      = r_wd_cnt;
    w_fifo_wr_next     = 1'b0;
    w_fifo_din_next    = r_fifo_din;
    w_err_timeout_next = 1'b0;
    w_err_id_next      = r_err_id;
    case (r_state)
      ST_IDLE: begin
        if (i_module_en && w_pick_any) begin
          w_grant_next  = w_pick_onehot;
          w_gidx_next   = w_pick_idx;
          w_wd_cnt_next = '0;
`ifdef UART_ARB_ID_HDR_EN
          w_state_next  = ST_HDR;
`else
          w_state_next  = ST_DATA;
`endif
        end
      end
`ifdef UART_ARB_ID_HDR_EN
      ST_HDR: begin
        if (w_space) begin
          w_fifo_wr_next  = 1'b1;
          w_fifo_din_next = {HDR_PREFIX, r_gidx};
          w_state_next    = ST_DATA;
        end
      end
`endif
      ST_DATA: begin
        if (w_xfer) begin
          w_fifo_wr_next  = 1'b1;
          w_fifo_din_next = w_sel_data;
          w_wd_cnt_next   = '0;
          if (w_sel_last) begin
            w_state_next  = ST_IDLE;
            w_rr_ptr_next = r_gidx;
            w_grant_next  = '0;
          end
        end else if (w_space) begin
          // Backpressure freezes the watchdog; only an idle owner with room to write is a stall.
          if (r_wd_cnt == WD_W'(TIMEOUT - 1)) begin
            w_err_timeout_next = 1'b1;
            w_err_id_next      = r_gidx;
            w_rr_ptr_next      = r_gidx;
            w_grant_next       = '0;
            w_wd_cnt_next      = '0;
            w_state_next       = ST_IDLE;
          end else begin
            w_wd_cnt_next = r_wd_cnt + WD_W'(1);
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_gidx        <= '0;
      r_rr_ptr      <= IDX_W'(N_REQ - 1);
      r_wd_cnt      <= '0;
      r_fifo_wr     <= 1'b0;
      r_fifo_din    <= '0;
      r_err_timeout <= 1'b0;
      r_err_id      <= '0;
    end else begin
      r_state       <= w_state_next;
      r_grant       <= w_grant_next;
      r_gidx        <= w_gidx_next;
      r_rr_ptr      <= w_rr_ptr_next;
      r_wd_cnt      <= w_wd_cnt_next;
      r_fifo_wr     <= w_fifo_wr_next;
      r_fifo_din    <= w_fifo_din_next;
      r_err_timeout <= w_err_timeout_next;
      r_err_id      <= w_err_id_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner sequences, randomized packets.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int DEPTH = 10;
  localparam int CW    = 16;
  localparam int TO    = 16;
`ifdef UART_ARB_ID_HDR_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            i_module_en;
  logic [N-1:0]    i_req_valid;
  logic [8*N-1:0]  i_req_data;
  logic [N-1:0]    i_req_last;
  logic [N-1:0]    o_req_ready;
  logic [CW-1:0]   i_fifo_cnt;
  logic            o_fifo_wr;
  logic [7:0]      o_fifo_din;
  logic [N-1:0]    o_grant;
  logic            o_busy;
  logic            o_err_timeout;
  logic [2:0]      o_err_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ(N), .FIFO_DEPTH(DEPTH), .CNT_W(CW), .TIMEOUT(TO)
  ) dut (
    .i_sys_clk     (clk),
    .i_sys_rst     (rst),
    .i_module_en   (i_module_en),
    .i_req_valid   (i_req_valid),
    .i_req_data    (i_req_data),
    .i_req_last    (i_req_last),
    .o_req_ready   (o_req_ready),
    .i_fifo_cnt    (i_fifo_cnt),
    .o_fifo_wr     (o_fifo_wr),
    .o_fifo_din    (o_fifo_din),
    .o_grant       (o_grant),
    .o_busy        (o_busy),
    .o_err_timeout (o_err_timeout),
    .o_err_id      (o_err_id)
  );

  int checks = 0;
  int errors = 0;

  // Per-requester packet sources: {last, byte}
  logic [8:0] src_mem [N][64];
  int         src_len [N];
  int         src_head[N];
  logic [7:0] exp_q[$];
  int         wr_cyc[$];
  logic [7:0] wr_dat[$];
  logic [N-1:0] g_log[256];
  int         m_ptr;

  typedef struct {
    logic         en;
    logic [N-1:0] valid;
    int           cnt;
    logic [N-1:0] exp_grant;
    logic [N-1:0] exp_ready;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    i_module_en = 1'b0;
    i_req_valid = '0;
    i_req_data  = '0;
    i_req_last  = '0;
    i_fifo_cnt  = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    m_ptr = N - 1;
  endtask

  task automatic clear_src();
    for (int k = 0; k < N; k++) begin
      src_len[k]  = 0;
      src_head[k] = 0;
    end
  endtask

  task automatic add_byte(input int k, input logic [7:0] b, input logic last);
    src_mem[k][src_len[k]] = {last, b};
    src_len[k]++;
  endtask

  // Reference order: with every holder of a packet requesting continuously, packets leave in
  // strict rotation starting after the last served requester, each packet contiguous.
  task automatic build_expected();
    int head[N];
    int k;
    bit found;
    logic [8:0] e;
    logic [2:0] kid;
    exp_q.delete();
    for (int i = 0; i < N; i++) head[i] = 0;
    while (1) begin
      found = 0;
      k = 0;
      for (int d = 1; d <= N; d++) begin
        if (!found && head[(m_ptr + d) % N] < src_len[(m_ptr + d) % N]) begin
          found = 1;
          k = (m_ptr + d) % N;
        end
      end
      if (!found) break;
      kid = 3'(k);
      if (H == 1) exp_q.push_back({5'b10100, kid});
      while (head[k] < src_len[k]) begin
        e = src_mem[k][head[k]];
        head[k]++;
        exp_q.push_back(e[7:0]);
        if (e[8]) break;
      end
      m_ptr = k;
    end
  endtask

  task automatic drive_src();
    logic [N-1:0]   v;
    logic [N-1:0]   l;
    logic [8*N-1:0] d;
    logic [8:0]     e;
    v = '0; l = '0; d = '0;
    for (int k = 0; k < N; k++) begin
      if (src_head[k] < src_len[k]) begin
        e = src_mem[k][src_head[k]];
        v[k] = 1'b1;
        l[k] = e[8];
        d[8*k +: 8] = e[7:0];
      end
    end
    i_req_valid = v;
    i_req_data  = d;
    i_req_last  = l;
  endtask

  // Runs loaded sources to completion against a FIFO model whose count rises on each write
  // and drains randomly; no draining during the first `hold` steps.
  task automatic run_engine(input string name, input int init_cnt, input int hold, input int drop_to,
                            input int drain_pct, input int max_cycles, output int wr_at_hold);
    int cnt, idx, err_pulses;
    bit done, all_sent;
    logic [N-1:0] acc;
    logic wr;
    logic [7:0] din;
    build_expected();
    idx = 0; cnt = init_cnt; err_pulses = 0; done = 0; wr_at_hold = -1;
    wr_cyc.delete();
    wr_dat.delete();
    i_module_en = 1'b1;
    i_fifo_cnt  = CW'(cnt);
    for (int s = 0; s < max_cycles; s++) begin
      drive_src();
      @(negedge clk);
      acc = i_req_valid & o_req_ready;
      wr  = o_fifo_wr;
      din = o_fifo_din;
      if (s < 256) g_log[s] = o_grant;
      if (o_err_timeout) err_pulses++;
      check("grant_onehot", $onehot0(o_grant), 1);
      check("ready_in_grant", o_req_ready & ~o_grant, 0);
      if (wr) begin
        wr_cyc.push_back(s);
        wr_dat.push_back(din);
        $display("wr %s #%0d cyc=%0d data=0x%02h", name, idx, s, din);
        if (idx < exp_q.size()) check("wr_data", din, exp_q[idx]);
        check("no_overfill", (cnt + 1 <= DEPTH), 1);
        idx++;
      end
      if (s == hold) wr_at_hold = idx;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) if (acc[k]) src_head[k]++;
      if (wr) cnt++;
      if (s >= hold) begin
        if (s == hold && drop_to >= 0 && cnt > drop_to) cnt = drop_to;
        if (cnt > 0 && $urandom_range(0, 99) < drain_pct) cnt--;
      end
      i_fifo_cnt = CW'(cnt);
      all_sent = 1;
      for (int k = 0; k < N; k++) if (src_head[k] < src_len[k]) all_sent = 0;
      if (all_sent && idx >= exp_q.size() && !o_busy && s > hold) begin
        done = 1;
        break;
      end
    end
    drive_src();
    check("engine_done", done, 1);
    check("stream_len", idx, exp_q.size());
    check("no_timeout", err_pulses, 0);
  endtask

  initial begin
    int n, stale_wr, wh;
    rst = 1'b1;
    vecs[0] = '{1'b1, 4'b0001,  0, 4'b0001, 4'b0001};
    vecs[1] = '{1'b1, 4'b1010,  0, 4'b0010, 4'b0010};
    vecs[2] = '{1'b1, 4'b1100,  9, 4'b0100, 4'b0100};
    vecs[3] = '{1'b1, 4'b1000, 10, 4'b1000, 4'b0000};
    vecs[4] = '{1'b0, 4'b1111,  0, 4'b0000, 4'b0000};
    vecs[5] = '{1'b1, 4'b0000,  0, 4'b0000, 4'b0000};
    vecs[6] = '{1'b1, 4'b1111, 12, 4'b0001, 4'b0000};

    // Reset state
    do_reset();
    check("rst_wr", o_fifo_wr, 0);
    check("rst_din", o_fifo_din, 0);
    check("rst_grant", o_grant, 0);
    check("rst_busy", o_busy, 0);
    check("rst_err", o_err_timeout, 0);
    check("rst_err_id", o_err_id, 0);
    check("rst_ready", o_req_ready, 0);

    // First-grant vector table
    for (int i = 0; i < 7; i++) begin
      do_reset();
      i_module_en = vecs[i].en;
      i_req_valid = vecs[i].valid;
      i_req_last  = '1;
      i_fifo_cnt  = CW'(vecs[i].cnt);
      step();
      $display("vec %0d en=%0b valid=%b cnt=%0d grant=%b ready=%b", i, vecs[i].en, vecs[i].valid,
               vecs[i].cnt, o_grant, o_req_ready);
      check("vec_grant", o_grant, vecs[i].exp_grant);
      check("vec_busy", o_busy, |vecs[i].exp_grant);
      check("vec_ready", o_req_ready, (H == 1) ? 4'b0000 : vecs[i].exp_ready);
    end

    // Single 3-byte packet: latency and grant window
    do_reset();
    clear_src();
    add_byte(0, 8'h41, 1'b0);
    add_byte(0, 8'h42, 1'b0);
    add_byte(0, 8'h43, 1'b1);
    run_engine("single", 0, 0, -1, 100, 200, wh);
    check("single_nwr", wr_cyc.size(), 3 + H);
    if (wr_cyc.size() >= 3 + H) begin
      check("single_first_cyc", wr_cyc[H], 2 + H);
      check("single_last_cyc", wr_cyc[2 + H], 4 + H);
    end
    check("single_grant_on", g_log[2 + H], 4'b0001);
    check("single_grant_off", g_log[4 + H], 4'b0000);

    // Three simultaneous requesters, then rotation after requester 0 is served alone
    do_reset();
    clear_src();
    for (int k = 0; k < 3; k++) begin
      add_byte(k, 8'(16 * (k + 1)), 1'b0);
      add_byte(k, 8'(16 * (k + 1) + 1), 1'b1);
    end
    run_engine("rr_round1", 0, 0, -1, 100, 300, wh);
    if (wr_dat.size() == 6 + 3 * H) check("rr1_first", wr_dat[H], 8'h10);
    clear_src();
    add_byte(0, 8'h10, 1'b0);
    add_byte(0, 8'h11, 1'b1);
    run_engine("rr_round2", 0, 0, -1, 100, 300, wh);
    clear_src();
    for (int k = 0; k < 3; k++) begin
      add_byte(k, 8'(16 * (k + 1)), 1'b0);
      add_byte(k, 8'(16 * (k + 1) + 1), 1'b1);
    end
    run_engine("rr_round3", 0, 0, -1, 100, 300, wh);
    check("rr3_nwr", wr_dat.size(), 6 + 3 * H);
    if (wr_dat.size() == 6 + 3 * H) begin
      check("rr3_first", wr_dat[H], 8'h20);
      check("rr3_last", wr_dat[5 + 3 * H], 8'h11);
    end

    // Backpressure: count 9 admits one byte, hold past the watchdog, then drop to 5
    do_reset();
    clear_src();
    for (int i = 0; i < 4; i++) add_byte(1, 8'(8'hB0 + i), (i == 3));
    run_engine("backpressure", 9, 40, 5, 50, 600, wh);
    check("bp_writes_held", wh, 1);

    // Watchdog: requester 2 stalls mid-packet, requester 3 pending
    do_reset();
    i_module_en = 1'b1;
    i_req_valid = 4'b1100;
    i_req_data  = {8'h30, 8'h20, 16'h0000};
    i_req_last  = 4'b1000;
    i_fifo_cnt  = '0;
    n = 0;
    while (!o_req_ready[2] && n < 10) begin
      step();
      n++;
    end
    check("wd_ready", o_req_ready[2], 1);
    step();
    check("wd_first_wr", o_fifo_wr, 1);
    check("wd_first_din", o_fifo_din, 8'h20);
    i_req_valid = 4'b1000;
    stale_wr = 0;
    for (n = 1; n <= 40; n++) begin
      step();
      if (o_fifo_wr) stale_wr++;
      if (o_err_timeout) break;
    end
    $display("watchdog fired after %0d cycles id=%0d", n, o_err_id);
    check("wd_cycles", n, TO);
    check("wd_err_id", o_err_id, 2);
    check("wd_busy", o_busy, 0);
    check("wd_grant", o_grant, 0);
    check("wd_stale", stale_wr, 0);
    step();
    check("wd_pulse_end", o_err_timeout, 0);
    check("wd_next_grant", o_grant, 4'b1000);
    check("wd_id_held", o_err_id, 2);

    // Asynchronous reset mid-packet
    do_reset();
    i_module_en = 1'b1;
    i_req_valid = 4'b0010;
    i_req_data  = {16'h0000, 8'h77, 8'h00};
    i_req_last  = 4'b0000;
    n = 0;
    while (!o_fifo_wr && n < 10) begin
      step();
      n++;
    end
    check("ar_pre_wr", o_fifo_wr, 1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_wr", o_fifo_wr, 0);
    check("ar_grant", o_grant, 0);
    check("ar_busy", o_busy, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    i_req_valid = 4'b1001;
    i_req_data  = {8'h03, 16'h0000, 8'h01};
    i_req_last  = 4'b1001;
    step();
    check("ar_after_grant", o_grant, 4'b0001);
    check("ar_no_err", o_err_timeout, 0);

    // Randomized packets against the rotation model
    do_reset();
    for (int it = 0; it < 25; it++) begin
      clear_src();
      for (int k = 0; k < N; k++) begin
        int np;
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          int len;
          len = $urandom_range(1, 5);
          for (int b = 0; b < len; b++) add_byte(k, 8'($urandom), (b == len - 1));
        end
      end
      run_engine("rand", $urandom_range(0, DEPTH), 0, -1, $urandom_range(25, 100), 3000, wh);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
